// File: rtl/uart_baudgen_prog.sv
// Runtime-programmable fractional baud generator: a phase accumulator emits tick_os on each
// carry, and every OVERSAMPLE-th carry also emits tick_1x. Rate changes are staged in a shadow.
module uart_baudgen_prog #(
    parameter int unsigned ACCWIDTH    = 24,
    parameter int unsigned OVERSAMPLE  = 16,
    parameter int unsigned DEFAULT_INC = 1611
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [ACCWIDTH-1:0] inc_in,
    input  logic                inc_load,
    input  logic                resync,
    output logic                tick_os,
    output logic                tick_1x,
    output logic                inc_pend,
    output logic [ACCWIDTH-1:0] inc_cur
);
    localparam int unsigned SubW = $clog2(OVERSAMPLE);
    localparam logic [SubW-1:0] SubLast = SubW'(OVERSAMPLE - 1);
    localparam logic [SubW-1:0] SubMid = SubW'(OVERSAMPLE / 2);
    localparam logic [ACCWIDTH-1:0] IncRst = ACCWIDTH'(DEFAULT_INC);

    logic [ACCWIDTH-1:0] acc_q, acc_d;
    logic [ACCWIDTH-1:0] inc_act_q, inc_act_d;
    logic [ACCWIDTH-1:0] shadow_q, shadow_d;
    logic [SubW-1:0]     sub_q, sub_d;
    logic                pend_q, pend_d;
    logic                tick_os_q, tick_os_d;
    logic                tick_1x_q, tick_1x_d;
    logic [ACCWIDTH:0]   sum;
    logic                carry;

    always_comb begin
        sum       = {1'b0, acc_q} + {1'b0, inc_act_q};
        carry     = sum[ACCWIDTH];
        acc_d     = acc_q;
        sub_d     = sub_q;
        inc_act_d = inc_act_q;
        shadow_d  = shadow_q;
        pend_d    = pend_q;
        tick_os_d = 1'b0;
        tick_1x_d = 1'b0;
        if (resync) begin
            // Restart at phase zero half a bit early so tick_1x lands mid-bit.
            acc_d  = '0;
            sub_d  = SubMid;
            pend_d = 1'b0;
            if (inc_load) begin
                inc_act_d = inc_in;
            end else if (pend_q) begin
                inc_act_d = shadow_q;
            end
        end else if (en) begin
            acc_d     = sum[ACCWIDTH-1:0];
            tick_os_d = carry;
            tick_1x_d = carry && (sub_q == SubLast);
            if (carry) begin
                sub_d = sub_q + 1'b1;
                // Commit only at a tick boundary so no period is shortened or stretched.
                if (pend_q) begin
                    inc_act_d = shadow_q;
                    pend_d    = 1'b0;
                end
            end
            if (inc_load) begin
                shadow_d = inc_in;
                pend_d   = 1'b1;
            end
        end else if (inc_load) begin
            inc_act_d = inc_in;
            pend_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q     <= '0;
            sub_q     <= '0;
            inc_act_q <= IncRst;
            shadow_q  <= '0;
            pend_q    <= 1'b0;
            tick_os_q <= 1'b0;
            tick_1x_q <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            sub_q     <= sub_d;
            inc_act_q <= inc_act_d;
            shadow_q  <= shadow_d;
            pend_q    <= pend_d;
            tick_os_q <= tick_os_d;
            tick_1x_q <= tick_1x_d;
        end
    end

    assign tick_os  = tick_os_q;
    assign tick_1x  = tick_1x_q;
    assign inc_pend = pend_q;
    assign inc_cur  = inc_act_q;

endmodule

// File: tb/tb_uart_baudgen_prog.sv
// Bench for uart_baudgen_prog (W=8, OVERSAMPLE=4, DEFAULT_INC=128): expected tick cycles are
// queued as stimulus is planned and matched against tick_os/tick_1x every cycle.
module tb_uart_baudgen_prog;
    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst, en, inc_load, resync;
    logic [W-1:0] inc_in;
    logic         tick_os, tick_1x, inc_pend;
    logic [W-1:0] inc_cur;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int t0 = 0;
    int q_os[$];
    int q_1x[$];

    uart_baudgen_prog #(
        .ACCWIDTH   (W),
        .OVERSAMPLE (4),
        .DEFAULT_INC(128)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .inc_in  (inc_in),
        .inc_load(inc_load),
        .resync  (resync),
        .tick_os (tick_os),
        .tick_1x (tick_1x),
        .inc_pend(inc_pend),
        .inc_cur (inc_cur)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic do_reset(input logic en_val);
        @(negedge clk);
        rst = 1'b1; en = en_val; inc_load = 1'b0; resync = 1'b0; inc_in = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        t0  = cyc;
        q_os.delete();
        q_1x.delete();
    endtask

    // Accumulator arithmetic from phase 0: a tick on every step where floor(inc*k/256) rises.
    task automatic push_acc(input int start, input int inc, input int sub0, input int n);
        int j = 0;
        for (int k = 1; k <= n; k++) begin
            if ((inc * k) / 256 != (inc * (k - 1)) / 256) begin
                j++;
                q_os.push_back(start + k);
                if ((sub0 + j - 1) % 4 == 3) q_1x.push_back(start + k);
            end
        end
    endtask

    task automatic test_reset();
        logic e_os, e_1x;
        @(negedge clk);
        rst = 1'b1; en = 1'b1;
        @(negedge clk);
        checks++;
        if (tick_os !== 1'b0 || tick_1x !== 1'b0 || inc_pend !== 1'b0 || inc_cur !== 8'd128) begin
            errors++;
            $display("FAIL reset_state got os=%b 1x=%b pend=%b cur=%0d want 0 0 0 128",
                     tick_os, tick_1x, inc_pend, inc_cur);
        end
        do_reset(1'b1);
        for (int k = 1; k <= 16; k++) q_os.push_back(t0 + 2 * k);
        for (int k = 1; k <= 4; k++) q_1x.push_back(t0 + 8 * k);
        while (cyc < t0 + 32) begin
            @(negedge clk);
            e_os = (q_os.size() > 0) && (q_os[0] == cyc);
            e_1x = (q_1x.size() > 0) && (q_1x[0] == cyc);
            checks++;
            if (tick_os !== e_os || tick_1x !== e_1x) begin
                errors++;
                $display("FAIL reset_run cyc=%0d os/1x got %b%b want %b%b",
                         cyc - t0, tick_os, tick_1x, e_os, e_1x);
            end
            if (e_os) void'(q_os.pop_front());
            if (e_1x) void'(q_1x.pop_front());
        end
        checks++;
        if (q_os.size() != 0 || q_1x.size() != 0) begin
            errors++;
            $display("FAIL reset_drain left %0d/%0d want 0/0", q_os.size(), q_1x.size());
        end
    endtask

    task automatic test_load_mid();
        logic e_os, e_1x;
        do_reset(1'b1);
        q_os = '{t0 + 2, t0 + 4, t0 + 6};
        for (int c = 10; c <= 42; c += 4) q_os.push_back(t0 + c);
        q_1x = '{t0 + 10, t0 + 26, t0 + 42};
        while (cyc < t0 + 44) begin
            @(negedge clk);
            e_os = (q_os.size() > 0) && (q_os[0] == cyc);
            e_1x = (q_1x.size() > 0) && (q_1x[0] == cyc);
            checks++;
            if (tick_os !== e_os || tick_1x !== e_1x) begin
                errors++;
                $display("FAIL load_mid_run cyc=%0d os/1x got %b%b want %b%b",
                         cyc - t0, tick_os, tick_1x, e_os, e_1x);
            end
            if (e_os) void'(q_os.pop_front());
            if (e_1x) void'(q_1x.pop_front());
            if (cyc == t0 + 5) begin
                checks++;
                if (inc_pend !== 1'b1 || inc_cur !== 8'd128) begin
                    errors++;
                    $display("FAIL load_mid_pend got pend=%b cur=%0d want 1 128", inc_pend, inc_cur);
                end
            end
            if (cyc == t0 + 6) begin
                checks++;
                if (inc_pend !== 1'b0 || inc_cur !== 8'd64) begin
                    errors++;
                    $display("FAIL load_mid_commit got pend=%b cur=%0d want 0 64", inc_pend, inc_cur);
                end
            end
            inc_load = (cyc == t0 + 4);
            inc_in   = 8'd64;
        end
    endtask

    task automatic test_back_to_back();
        logic e_os, e_1x;
        do_reset(1'b1);
        q_os = '{t0 + 2, t0 + 4, t0 + 12};
        for (int c = 16; c <= 36; c += 4) q_os.push_back(t0 + c);
        q_1x = '{t0 + 16, t0 + 32};
        while (cyc < t0 + 36) begin
            @(negedge clk);
            e_os = (q_os.size() > 0) && (q_os[0] == cyc);
            e_1x = (q_1x.size() > 0) && (q_1x[0] == cyc);
            checks++;
            if (tick_os !== e_os || tick_1x !== e_1x) begin
                errors++;
                $display("FAIL b2b_run cyc=%0d os/1x got %b%b want %b%b",
                         cyc - t0, tick_os, tick_1x, e_os, e_1x);
            end
            if (e_os) void'(q_os.pop_front());
            if (e_1x) void'(q_1x.pop_front());
            if (cyc == t0 + 3 || cyc == t0 + 4 || cyc == t0 + 11 || cyc == t0 + 12) begin
                logic       w_pend;
                logic [7:0] w_cur;
                w_pend = (cyc != t0 + 12);
                w_cur  = (cyc == t0 + 3) ? 8'd128 : (cyc == t0 + 12) ? 8'd64 : 8'd32;
                checks++;
                if (inc_pend !== w_pend || inc_cur !== w_cur) begin
                    errors++;
                    $display("FAIL b2b_state cyc=%0d got pend=%b cur=%0d want %b %0d",
                             cyc - t0, inc_pend, inc_cur, w_pend, w_cur);
                end
            end
            inc_load = (cyc == t0 + 2) || (cyc == t0 + 3) || (cyc == t0 + 5);
            inc_in   = (cyc == t0 + 2) ? 8'd32 : (cyc == t0 + 3) ? 8'd16 : 8'd64;
        end
    endtask

    task automatic test_en_off();
        logic e_os, e_1x;
        int   n_obs = 0;
        do_reset(1'b0);
        push_acc(t0 + 6, 85, 0, 772);
        while (cyc < t0 + 788) begin
            @(negedge clk);
            e_os = (q_os.size() > 0) && (q_os[0] == cyc);
            e_1x = (q_1x.size() > 0) && (q_1x[0] == cyc);
            checks++;
            if (tick_os !== e_os || tick_1x !== e_1x) begin
                errors++;
                $display("FAIL en_off_run cyc=%0d os/1x got %b%b want %b%b",
                         cyc - t0, tick_os, tick_1x, e_os, e_1x);
            end
            if (e_os) void'(q_os.pop_front());
            if (e_1x) void'(q_1x.pop_front());
            if (tick_os === 1'b1 && cyc >= t0 + 7 && cyc <= t0 + 778) n_obs++;
            if (cyc == t0 + 3) begin
                checks++;
                if (inc_pend !== 1'b0 || inc_cur !== 8'd85) begin
                    errors++;
                    $display("FAIL en_off_load got pend=%b cur=%0d want 0 85", inc_pend, inc_cur);
                end
            end
            inc_load = (cyc == t0 + 2);
            inc_in   = 8'd85;
            en       = (cyc >= t0 + 6) && (cyc < t0 + 778);
        end
        checks++;
        if (n_obs != 256) begin
            errors++;
            $display("FAIL en_off_rate got %0d ticks in 772 clks want 256", n_obs);
        end
        en = 1'b1;
    endtask

    task automatic test_resync();
        logic e_os, e_1x;
        do_reset(1'b1);
        q_os = '{t0 + 2, t0 + 4, t0 + 6, t0 + 8};
        for (int c = 12; c <= 32; c += 2) q_os.push_back(t0 + c);
        q_1x = '{t0 + 8, t0 + 14, t0 + 22, t0 + 30};
        while (cyc < t0 + 32) begin
            @(negedge clk);
            e_os = (q_os.size() > 0) && (q_os[0] == cyc);
            e_1x = (q_1x.size() > 0) && (q_1x[0] == cyc);
            checks++;
            if (tick_os !== e_os || tick_1x !== e_1x) begin
                errors++;
                $display("FAIL resync_run cyc=%0d os/1x got %b%b want %b%b",
                         cyc - t0, tick_os, tick_1x, e_os, e_1x);
            end
            if (e_os) void'(q_os.pop_front());
            if (e_1x) void'(q_1x.pop_front());
            resync = (cyc == t0 + 9);
        end
    endtask

    task automatic test_rst_mid();
        logic e_os, e_1x;
        int   t1;
        do_reset(1'b1);
        q_os = '{t0 + 2};
        while (cyc < t0 + 17) begin
            @(negedge clk);
            e_os = (q_os.size() > 0) && (q_os[0] == cyc);
            e_1x = (q_1x.size() > 0) && (q_1x[0] == cyc);
            checks++;
            if (tick_os !== e_os || tick_1x !== e_1x) begin
                errors++;
                $display("FAIL rst_mid_run cyc=%0d os/1x got %b%b want %b%b",
                         cyc - t0, tick_os, tick_1x, e_os, e_1x);
            end
            if (e_os) void'(q_os.pop_front());
            if (e_1x) void'(q_1x.pop_front());
            if (cyc == t0 + 3) begin
                checks++;
                if (inc_pend !== 1'b1) begin
                    errors++;
                    $display("FAIL rst_mid_pend got pend=%b want 1", inc_pend);
                end
            end
            if (cyc == t0 + 4) begin
                checks++;
                if (inc_pend !== 1'b0 || inc_cur !== 8'd128) begin
                    errors++;
                    $display("FAIL rst_mid_state got pend=%b cur=%0d want 0 128", inc_pend, inc_cur);
                end
            end
            inc_load = (cyc == t0 + 2);
            inc_in   = 8'd64;
            rst      = (cyc == t0 + 3) || (cyc == t0 + 4);
            if (cyc == t0 + 5) begin
                t1 = cyc;
                for (int k = 1; k <= 6; k++) q_os.push_back(t1 + 2 * k);
                q_1x.push_back(t1 + 8);
            end
        end
    endtask

    task automatic test_resync_load();
        logic e_os, e_1x;
        int   n_obs = 0;
        do_reset(1'b1);
        q_os = '{t0 + 2};
        push_acc(t0 + 3, 255, 2, 260);
        while (cyc < t0 + 263) begin
            @(negedge clk);
            e_os = (q_os.size() > 0) && (q_os[0] == cyc);
            e_1x = (q_1x.size() > 0) && (q_1x[0] == cyc);
            checks++;
            if (tick_os !== e_os || tick_1x !== e_1x) begin
                errors++;
                $display("FAIL rs_load_run cyc=%0d os/1x got %b%b want %b%b",
                         cyc - t0, tick_os, tick_1x, e_os, e_1x);
            end
            if (e_os) void'(q_os.pop_front());
            if (e_1x) void'(q_1x.pop_front());
            if (tick_os === 1'b1 && cyc >= t0 + 5 && cyc <= t0 + 260) n_obs++;
            if (cyc == t0 + 3) begin
                checks++;
                if (inc_pend !== 1'b0 || inc_cur !== 8'd255) begin
                    errors++;
                    $display("FAIL rs_load_state got pend=%b cur=%0d want 0 255", inc_pend, inc_cur);
                end
            end
            inc_load = (cyc == t0 + 2);
            resync   = (cyc == t0 + 2);
            inc_in   = 8'd255;
        end
        checks++;
        if (n_obs != 255) begin
            errors++;
            $display("FAIL rs_load_rate got %0d ticks in 256 clks want 255", n_obs);
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; inc_load = 1'b0; resync = 1'b0; inc_in = '0;
        test_reset();
        test_load_mid();
        test_back_to_back();
        test_en_off();
        test_resync();
        test_rst_mid();
        test_resync_load();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout cyc=%0d want completion", cyc);
        $fatal(1, "timeout");
    end

endmodule
